// File: rtl/dmem_responder.sv
// Multi-cycle data memory responder for the MEM-stage load/store port.
// Accepts one request at a time and completes it after a set number of wait cycles.
module dmem_responder #(
    parameter int DEPTH       = 256,
    parameter int AW          = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Req,
    input  logic        DMWE,
    input  logic [31:0] DMA,
    input  logic [31:0] DMWD,
    output logic [31:0] DMRD,
    output logic        Ack,
    output logic        Stall,
    output logic        Err
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic          we;
    logic          oor;
    logic          dma_oor;
    logic [31:0]   ram [DEPTH];

    assign dma_oor = |DMA[31:AW];
    assign Stall   = Req & ~Ack;

    // Request capture, wait countdown and registered completion outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
            addr  <= '0;
            wdata <= '0;
            we    <= 1'b0;
            oor   <= 1'b0;
            DMRD  <= '0;
            Ack   <= 1'b0;
            Err   <= 1'b0;
        end else begin
            Ack <= 1'b0;
            Err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (Req) begin
                        addr  <= DMA[AW-1:0];
                        wdata <= DMWD;
                        we    <= DMWE;
                        oor   <= dma_oor;
                        if (WAIT_CYCLES == 0) begin
                            state <= DONE;
                            cnt   <= '0;
                            Ack   <= 1'b1;
                            Err   <= dma_oor;
                            if (!DMWE) begin
                                DMRD <= dma_oor ? '0 : ram[DMA[AW-1:0]];
                            end
                        end else begin
                            state <= BUSY;
                            cnt   <= 4'(WAIT_CYCLES);
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (cnt <= 4'd1) begin
                        state <= DONE;
                        Ack   <= 1'b1;
                        Err   <= oor;
                        if (!we) begin
                            DMRD <= oor ? '0 : ram[addr];
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Writes land at the closing edge of DONE; a reset on that edge cancels them.
    always_ff @(posedge CLK) begin
        if (!RST && state == DONE && we && !oor) begin
            ram[addr] <= wdata;
        end
    end

endmodule
